hiscore_dump: RTL
=================

HISCORE_DUMP -- requirements
Module: hiscore_dump

Interface
REQ-001 SHALL have parameter RAM_AW, default 12, game RAM address width.
REQ-002 SHALL have parameter BUF_AW, default 8, dump buffer address width (256 bytes).
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port ioctl_download, input, 1, HPS download active.
REQ-006 SHALL have port ioctl_upload, input, 1, HPS upload active.
REQ-007 SHALL have port ioctl_wr, input, 1, download byte strobe.
REQ-008 SHALL have port ioctl_index, input, 8, download stream index.
REQ-009 SHALL have port ioctl_addr, input, 25, byte address for download and upload.
REQ-010 SHALL have port ioctl_dout, input, 8, download data byte.
REQ-011 SHALL have port ioctl_din, output, 8, upload data byte.
REQ-012 SHALL have port dump_req, input, 1, single-cycle request to capture game RAM.
REQ-013 SHALL have port ram_address, output, RAM_AW, game RAM read address.
REQ-014 SHALL have port ram_rd, output, 1, game RAM read strobe.
REQ-015 SHALL have port ram_data, input, 8, game RAM read data, valid the cycle after ram_rd.
REQ-016 SHALL have ports busy, done, overflow, output, 1 each, status flags.
REQ-017 SHALL have port byte_count, output, BUF_AW+1, number of bytes captured.

Function
REQ-018 SHALL store a 16-entry table written when ioctl_download & ioctl_wr & ioctl_index==3; entry = ioctl_addr[6:3], byte offset = ioctl_addr[2:0].
REQ-019 SHALL take the entry base address from offsets 2 (high) and 3 (low), truncated to RAM_AW, and length from offset 4; offsets 0,1,5,6,7 SHALL be ignored.
REQ-020 SHALL set total_entries to the highest entry index written since the start of the current index-3 download (cleared to 0 on its rising edge).
REQ-021 SHALL run FSM IDLE -> LOAD -> READ <-> CAPT -> NEXT -> (LOAD | DONE) -> IDLE.
REQ-022 IDLE: SHALL move to LOAD with entry=0, byte_count=0, overflow=0, done=0 when dump_req=1 and ioctl_upload=0 and ioctl_download=0; otherwise SHALL ignore dump_req.
REQ-023 LOAD: one cycle for table read; SHALL go to NEXT if length==0, else to READ with offset=0.
REQ-024 READ: SHALL drive ram_rd=1, ram_address=(base+offset) mod 2^RAM_AW; next state CAPT.
REQ-025 CAPT: SHALL write ram_data to buffer[byte_count], increment byte_count and offset; go to NEXT when offset+1==length, else READ.
REQ-026 SHALL, if a capture is due with byte_count==2^BUF_AW, skip the write, set overflow=1 and go to DONE.
REQ-027 NEXT: SHALL go to DONE if entry==total_entries, else increment entry and go to LOAD.
REQ-028 DONE: SHALL pulse done=1 for one cycle, then go to IDLE; done SHALL stay low at all other times.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 Cycle cost SHALL be 1 per entry (LOAD) + 2 per byte + 1 per entry (NEXT) + 1 (DONE).
REQ-031 ram_rd SHALL be 0 outside READ; ram_address SHALL hold its last value outside READ.
REQ-032 During upload, ioctl_din SHALL equal buffer[ioctl_addr[BUF_AW-1:0]] one cycle after ioctl_addr changes; addresses >= byte_count SHALL return 8'h00.
REQ-033 Table writes while busy SHALL be accepted and take effect for entries not yet loaded.
REQ-034 byte_count and buffer contents SHALL persist after DONE until the next accepted dump_req.

Reset
REQ-035 reset SHALL asynchronously force FSM=IDLE, busy=0, done=0, overflow=0, ram_rd=0, ram_address=0, byte_count=0, total_entries=0, ioctl_din=0.
REQ-036 Table and buffer RAM contents SHALL NOT be cleared by reset; reset mid-dump SHALL abort without further buffer writes.

Verification
REQ-037 Table entry0 {00 00 00 0B 0F 10 01 00}, RAM[0x00B..0x019]=0x10..0x1E, dump_req -> busy 33 cycles, done pulse, byte_count=15, buffer[0..14]=0x10..0x1E.
REQ-038 Two entries (0x023 len 4, 0x100 len 2) -> byte_count=6, buffer = RAM[0x023..0x026],RAM[0x100..0x101], ram_rd never asserted for lengths past each entry.
REQ-039 Entry base 0xFFE len 4 -> reads 0xFFE,0xFFF,0x000,0x001; entry with len 0 -> skipped, no ram_rd.
REQ-040 Three entries len 0xFF,0xFF,0x10 -> byte_count=256, overflow=1, done pulse, no write beyond buffer[255].
REQ-041 dump_req while ioctl_upload=1 or busy=1 -> ignored; upload addr 3 after dump -> ioctl_din=buffer[3] next cycle; addr 20 with byte_count=15 -> 8'h00.
REQ-042 reset asserted mid-CAPT -> all outputs at reset values same cycle, subsequent dump_req completes normally.

Source files
------------

// File: rtl/hiscore_dump.sv
// High-score RAM dumper: copies table-described game RAM regions into a local
// buffer on request, and serves that buffer to the HPS during upload.
module hiscore_dump #(
  parameter int RAM_AW = 12,
  parameter int BUF_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  input  logic              dump_req,
  output logic [RAM_AW-1:0] ram_address,
  output logic              ram_rd,
  input  logic [7:0]        ram_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [BUF_AW:0]   byte_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_CAPT, S_NEXT, S_DONE} state_t;
  localparam int BUF_SIZE = 1 << BUF_AW;

  logic [7:0] tbl_hi  [16];
  logic [7:0] tbl_lo  [16];
  logic [7:0] tbl_len [16];
  logic [7:0] buffer  [BUF_SIZE];

  state_t            state;
  logic [3:0]        entry;
  logic [3:0]        total_entries;
  logic [RAM_AW-1:0] cur_base;
  logic [7:0]        cur_len;
  logic [7:0]        offset;
  logic              dl3_q;

  logic              dl3;
  logic              tbl_we;
  logic [3:0]        wr_entry;
  logic [2:0]        wr_off;
  logic [15:0]       load_base16;
  logic [7:0]        offset_nxt;
  logic [RAM_AW+7:0] addr_sum;
  logic              buf_full;
  logic              buf_we;

  always_comb begin
    dl3         = ioctl_download && (ioctl_index == 8'd3);
    tbl_we      = dl3 && ioctl_wr;
    wr_entry    = ioctl_addr[6:3];
    wr_off      = ioctl_addr[2:0];
    load_base16 = {tbl_hi[entry], tbl_lo[entry]};
    offset_nxt  = offset + 8'd1;
    addr_sum    = {8'd0, cur_base} + {{RAM_AW{1'b0}}, offset_nxt};
    buf_full    = byte_count[BUF_AW];
    buf_we      = (state == S_CAPT) && !buf_full;
  end

  // Table and buffer storage deliberately have no reset so contents survive it.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      case (wr_off)
        3'd2:    tbl_hi[wr_entry]  <= ioctl_dout;
        3'd3:    tbl_lo[wr_entry]  <= ioctl_dout;
        3'd4:    tbl_len[wr_entry] <= ioctl_dout;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buffer[byte_count[BUF_AW-1:0]] <= ram_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl3_q         <= 1'b0;
      total_entries <= '0;
    end else begin
      dl3_q <= dl3;
      if (dl3 && !dl3_q)
        total_entries <= tbl_we ? wr_entry : '0;
      else if (tbl_we && (wr_entry > total_entries))
        total_entries <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ioctl_din <= '0;
    end else if (ioctl_addr < 25'(byte_count)) begin
      ioctl_din <= buffer[ioctl_addr[BUF_AW-1:0]];
    end else begin
      ioctl_din <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      ram_rd      <= 1'b0;
      ram_address <= '0;
      byte_count  <= '0;
      entry       <= '0;
      cur_base    <= '0;
      cur_len     <= '0;
      offset      <= '0;
    end else begin
      ram_rd <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dump_req && !ioctl_upload && !ioctl_download) begin
            entry      <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          cur_base <= RAM_AW'(load_base16);
          cur_len  <= tbl_len[entry];
          offset   <= '0;
          if (tbl_len[entry] == 8'd0) begin
            state <= S_NEXT;
          end else begin
            ram_rd      <= 1'b1;
            ram_address <= RAM_AW'(load_base16);
            state       <= S_READ;
          end
        end
        S_READ: state <= S_CAPT;
        S_CAPT: begin
          if (buf_full) begin
            overflow <= 1'b1;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            byte_count <= byte_count + 1'b1;
            offset     <= offset_nxt;
            if (offset_nxt == cur_len) begin
              state <= S_NEXT;
            end else begin
              // Address is computed one step ahead so ram_rd and ram_address are registered together.
              ram_rd      <= 1'b1;
              ram_address <= addr_sum[RAM_AW-1:0];
              state       <= S_READ;
            end
          end
        end
        S_NEXT: begin
          if (entry == total_entries) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            entry <= entry + 4'd1;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
